// File: rtl/spi_frame_receiver_if.sv
// SPI host lines and pixel RAM write port of the SPI frame receiver.
interface spi_frame_receiver_if #(
   parameter int WORD_BITS = 16,
   parameter int ADDR_BITS = 11
);
   logic                 spi_clk;
   logic                 spi_cs_n;
   logic                 spi_mosi;
   logic                 spi_miso;
   logic [WORD_BITS-1:0] write_data;
   logic [ADDR_BITS-1:0] write_addr;
   logic                 write_en;
   logic                 write_buffer;
   logic                 frame_done;
   logic                 overrun;

   modport master (
      output spi_clk, spi_cs_n, spi_mosi,
      input  spi_miso, write_data, write_addr, write_en, write_buffer, frame_done, overrun
   );

   modport slave (
      input  spi_clk, spi_cs_n, spi_mosi,
      output spi_miso, write_data, write_addr, write_en, write_buffer, frame_done, overrun
   );
endinterface

// File: rtl/spi_frame_receiver.sv
// Oversampled SPI deserialiser feeding the dual-buffer HUB75 pixel RAM.
// Define SPI_ECHO_EN to echo the previous word on spi_miso.
//
// state   | meaning
// IDLE    | waiting for cs_n falling; counts overrun words after a flip
// RECEIVE | shifting bits in, writing each completed word
// FLIP    | one cycle: toggle write_buffer, pulse frame_done
module spi_frame_receiver #(
   parameter int WORD_BITS   = 16,
   parameter int ADDR_BITS   = 11,
   parameter int FRAME_WORDS = 2048,
   parameter int SYNC_STAGES = 2
) (
   input logic                 pixel_clk,
   input logic                 n_reset,
   spi_frame_receiver_if.slave bus
);

   localparam int BC_BITS = $clog2(WORD_BITS);
   localparam int WC_RAW  = $clog2(FRAME_WORDS + 1);
   localparam int WC_BITS = (WC_RAW > ADDR_BITS) ? WC_RAW : ADDR_BITS;
   localparam logic [BC_BITS-1:0] BIT_LAST  = BC_BITS'(WORD_BITS - 1);
   localparam logic [WC_BITS-1:0] WORD_LAST = WC_BITS'(FRAME_WORDS - 1);

   typedef enum logic [1:0] {IDLE, RECEIVE, FLIP} state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] clk_sync_q, mosi_sync_q, cs_sync_q;
   logic                   clk_s, mosi_s, cs_s;
   logic                   clk_prev, cs_prev;
   logic                   ev_rise, ev_cs_fall, ev_cs_rise, ev_mosi;

   logic [WORD_BITS-1:0] shift_q;
   logic [BC_BITS-1:0]   bit_count;
   logic [WC_BITS-1:0]   word_count;
   logic                 word_pending, abort_pending;
   logic                 word_done;

   logic counters_clr, pend_set, abort_set, write_go, flip_go, overrun_set, overrun_clr;

   assign clk_s  = clk_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s   = cs_sync_q[SYNC_STAGES-1];

   always_ff @(posedge pixel_clk or negedge n_reset) begin
      if (!n_reset) begin
         clk_sync_q  <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '1;
      end else begin
         clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.spi_clk};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
      end
   end

   // Gating on the previous cs_n level keeps a clock edge that coincides
   // with cs_n rising, so the final word of an aborted frame still lands.
   always_ff @(posedge pixel_clk or negedge n_reset) begin
      if (!n_reset) begin
         clk_prev   <= 1'b0;
         cs_prev    <= 1'b1;
         ev_rise    <= 1'b0;
         ev_cs_fall <= 1'b0;
         ev_cs_rise <= 1'b0;
         ev_mosi    <= 1'b0;
      end else begin
         clk_prev   <= clk_s;
         cs_prev    <= cs_s;
         ev_rise    <= clk_s & ~clk_prev & ~cs_prev;
         ev_cs_fall <= ~cs_s & cs_prev;
         ev_cs_rise <= cs_s & ~cs_prev;
         ev_mosi    <= mosi_s;
      end
   end

   assign word_done = ev_rise && (bit_count == BIT_LAST);

   always_ff @(posedge pixel_clk or negedge n_reset) begin
      if (!n_reset) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      counters_clr = 1'b0;
      pend_set     = 1'b0;
      abort_set    = 1'b0;
      write_go     = 1'b0;
      flip_go      = 1'b0;
      overrun_set  = 1'b0;
      overrun_clr  = 1'b0;
      case (state)
         IDLE: begin
            if (ev_cs_fall) begin
               counters_clr = 1'b1;
               overrun_clr  = 1'b1;
               state_nxt    = RECEIVE;
            end else if (word_done) begin
               overrun_set = 1'b1;
            end
         end
         RECEIVE: begin
            if (word_pending) begin
               write_go = 1'b1;
               if (word_count == WORD_LAST)          state_nxt = FLIP;
               else if (abort_pending || ev_cs_rise) state_nxt = IDLE;
            end else if (ev_cs_fall) begin
               counters_clr = 1'b1;
               overrun_clr  = 1'b1;
            end else if (word_done) begin
               pend_set  = 1'b1;
               abort_set = ev_cs_rise;
            end else if (ev_cs_rise) begin
               state_nxt = IDLE;
            end
         end
         FLIP: begin
            flip_go   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk or negedge n_reset) begin
      if (!n_reset) begin
         shift_q       <= '0;
         bit_count     <= '0;
         word_count    <= '0;
         word_pending  <= 1'b0;
         abort_pending <= 1'b0;
         bus.write_data   <= '0;
         bus.write_addr   <= '0;
         bus.write_en     <= 1'b0;
         bus.write_buffer <= 1'b0;
         bus.frame_done   <= 1'b0;
         bus.overrun      <= 1'b0;
      end else begin
         if (ev_rise) shift_q <= {shift_q[WORD_BITS-2:0], ev_mosi};
         if (counters_clr)  bit_count <= '0;
         else if (ev_rise)  bit_count <= (bit_count == BIT_LAST) ? '0 : bit_count + 1'b1;
         if (counters_clr)  word_count <= '0;
         else if (write_go) word_count <= word_count + 1'b1;
         word_pending  <= pend_set;
         abort_pending <= abort_set;
         bus.write_en  <= write_go;
         if (write_go) begin
            bus.write_data <= shift_q;
            bus.write_addr <= word_count[ADDR_BITS-1:0];
         end
         bus.frame_done <= flip_go;
         if (flip_go) bus.write_buffer <= ~bus.write_buffer;
         if (overrun_clr)      bus.overrun <= 1'b0;
         else if (overrun_set) bus.overrun <= 1'b1;
      end
   end

`ifdef SPI_ECHO_EN
   logic                 ev_fall;
   logic [WORD_BITS-1:0] echo_q;

   always_ff @(posedge pixel_clk or negedge n_reset) begin
      if (!n_reset) ev_fall <= 1'b0;
      else          ev_fall <= ~clk_s & clk_prev & ~cs_prev;
   end

   // bit_count of zero on a falling edge means a word just completed.
   always_ff @(posedge pixel_clk or negedge n_reset) begin
      if (!n_reset)        echo_q <= '0;
      else if (ev_cs_fall) echo_q <= '0;
      else if (ev_fall)    echo_q <= (bit_count == '0) ? shift_q : {echo_q[WORD_BITS-2:0], 1'b0};
   end

   assign bus.spi_miso = echo_q[WORD_BITS-1] & ~cs_s;
`else
   assign bus.spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver with a scaled-down 64-word frame.
module tb_spi_frame_receiver;

   localparam int WB  = 16;
   localparam int AB  = 6;
   localparam int FW  = 64;
   localparam int SS  = 2;
   localparam int H   = 6;
   localparam int LAT = 4;

   logic pixel_clk = 1'b0;
   logic n_reset   = 1'b0;

   spi_frame_receiver_if #(.WORD_BITS(WB), .ADDR_BITS(AB)) bus ();

   spi_frame_receiver #(
      .WORD_BITS(WB), .ADDR_BITS(AB), .FRAME_WORDS(FW), .SYNC_STAGES(SS)
   ) dut (
      .pixel_clk(pixel_clk),
      .n_reset  (n_reset),
      .bus      (bus)
   );

   always #5 pixel_clk = ~pixel_clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int rise_cyc = 0;
   logic [WB-1:0] echo_rx;

   int wr_cnt  = 0;
   int en_long = 0;
   int fd_cnt  = 0;
   int fd_long = 0;
   logic en_prev = 1'b0;
   logic fd_prev = 1'b0;
   logic [WB-1:0] wr_data_log [0:511];
   logic [AB-1:0] wr_addr_log [0:511];
   int            wr_cyc_log  [0:511];

   always @(posedge pixel_clk) cyc <= cyc + 1;

   always @(negedge pixel_clk) begin
      if (bus.write_en) begin
         if (wr_cnt < 512) begin
            wr_data_log[wr_cnt] <= bus.write_data;
            wr_addr_log[wr_cnt] <= bus.write_addr;
            wr_cyc_log[wr_cnt]  <= cyc;
         end
         wr_cnt <= wr_cnt + 1;
         if (en_prev) en_long <= en_long + 1;
      end
      en_prev <= bus.write_en;
      if (bus.frame_done) begin
         fd_cnt <= fd_cnt + 1;
         if (fd_prev) fd_long <= fd_long + 1;
      end
      fd_prev <= bus.frame_done;
   end

   task automatic spi_bit(input logic b);
      bus.spi_mosi = b;
      repeat (H) @(negedge pixel_clk);
      echo_rx = {echo_rx[WB-2:0], bus.spi_miso};
      bus.spi_clk = 1'b1;
      rise_cyc = cyc;
      repeat (H) @(negedge pixel_clk);
      bus.spi_clk = 1'b0;
   endtask

   task automatic spi_word(input logic [WB-1:0] w);
      for (int i = WB - 1; i >= 0; i--) spi_bit(w[i]);
   endtask

   task automatic cs_low();
      @(negedge pixel_clk);
      bus.spi_cs_n = 1'b0;
      repeat (H) @(negedge pixel_clk);
   endtask

   task automatic cs_high();
      repeat (H) @(negedge pixel_clk);
      bus.spi_cs_n = 1'b1;
      repeat (4 * H) @(negedge pixel_clk);
   endtask

   task automatic test_reset();
      logic [WB+AB+4:0] outs;
      repeat (5) @(negedge pixel_clk);
      outs = {bus.write_data, bus.write_addr, bus.write_en, bus.write_buffer,
              bus.frame_done, bus.overrun, bus.spi_miso};
      checks++;
      if (outs !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=0", outs);
      end
      n_reset = 1'b1;
      repeat (5) @(negedge pixel_clk);
      checks++;
      if (bus.write_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_write_en got=%b want=0", bus.write_en);
      end
   endtask

   task automatic test_single_word();
      int base = wr_cnt;
      int fd0  = fd_cnt;
      int el0  = en_long;
      cs_low();
      spi_word(16'hF0A5);
      cs_high();
      checks++;
      if (wr_cnt - base !== 1) begin
         failures++;
         $display("FAIL single_count got=%0d want=1", wr_cnt - base);
      end
      checks++;
      if (wr_data_log[base] !== 16'hF0A5) begin
         failures++;
         $display("FAIL single_data got=%h want=f0a5", wr_data_log[base]);
      end
      checks++;
      if (wr_addr_log[base] !== 6'd0) begin
         failures++;
         $display("FAIL single_addr got=%0d want=0", wr_addr_log[base]);
      end
      checks++;
      if (wr_cyc_log[base] - rise_cyc - 1 !== LAT) begin
         failures++;
         $display("FAIL single_latency got=%0d want=%0d", wr_cyc_log[base] - rise_cyc - 1, LAT);
      end
      checks++;
      if (en_long !== el0) begin
         failures++;
         $display("FAIL single_strobe_width got=%0d want=%0d", en_long, el0);
      end
      checks++;
      if (fd_cnt !== fd0) begin
         failures++;
         $display("FAIL single_frame_done got=%0d want=%0d", fd_cnt, fd0);
      end
      checks++;
      if (bus.write_data !== 16'hF0A5) begin
         failures++;
         $display("FAIL single_data_hold got=%h want=f0a5", bus.write_data);
      end
      checks++;
      if (echo_rx !== 16'h0000) begin
         failures++;
         $display("FAIL single_miso got=%h want=0000", echo_rx);
      end
   endtask

   task automatic test_full_frame();
      for (int f = 0; f < 2; f++) begin
         int base = wr_cnt;
         int fd0  = fd_cnt;
         logic [WB-1:0] tag = (f == 0) ? 16'h0000 : 16'hC000;
         logic          wb_want = (f == 0) ? 1'b1 : 1'b0;
         cs_low();
         for (int i = 0; i < FW; i++) spi_word(tag | WB'(i));
         cs_high();
         checks++;
         if (wr_cnt - base !== FW) begin
            failures++;
            $display("FAIL frame%0d_count got=%0d want=%0d", f, wr_cnt - base, FW);
         end
         for (int i = 0; i < FW; i++) begin
            checks++;
            if (wr_addr_log[base+i] !== AB'(i) || wr_data_log[base+i] !== (tag | WB'(i))) begin
               failures++;
               $display("FAIL frame%0d_word%0d got=%0d/%h want=%0d/%h", f, i,
                        wr_addr_log[base+i], wr_data_log[base+i], i, tag | WB'(i));
            end
         end
         checks++;
         if (fd_cnt - fd0 !== 1) begin
            failures++;
            $display("FAIL frame%0d_frame_done got=%0d want=1", f, fd_cnt - fd0);
         end
         checks++;
         if (bus.write_buffer !== wb_want) begin
            failures++;
            $display("FAIL frame%0d_write_buffer got=%b want=%b", f, bus.write_buffer, wb_want);
         end
      end
      checks++;
      if (fd_long !== 0 || en_long !== 0) begin
         failures++;
         $display("FAIL frame_pulse_width got=%0d/%0d want=0/0", fd_long, en_long);
      end
   endtask

   task automatic test_overrun();
      int base = wr_cnt;
      int fd0  = fd_cnt;
      cs_low();
      for (int i = 0; i < FW + 2; i++) spi_word(16'h5A00 | WB'(i));
      repeat (H) @(negedge pixel_clk);
      checks++;
      if (bus.overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_set got=%b want=1", bus.overrun);
      end
      cs_high();
      checks++;
      if (wr_cnt - base !== FW) begin
         failures++;
         $display("FAIL overrun_writes got=%0d want=%0d", wr_cnt - base, FW);
      end
      checks++;
      if (fd_cnt - fd0 !== 1 || bus.write_buffer !== 1'b1) begin
         failures++;
         $display("FAIL overrun_flip got=%0d/%b want=1/1", fd_cnt - fd0, bus.write_buffer);
      end
      checks++;
      if (bus.overrun !== 1'b1) begin
         failures++;
         $display("FAIL overrun_sticky got=%b want=1", bus.overrun);
      end
   endtask

   task automatic test_abort();
      int base = wr_cnt;
      int fd0  = fd_cnt;
      cs_low();
      checks++;
      if (bus.overrun !== 1'b0) begin
         failures++;
         $display("FAIL abort_overrun_clear got=%b want=0", bus.overrun);
      end
      for (int i = 0; i < 40; i++) spi_word(WB'(i * 3));
      for (int i = 0; i < 5; i++) spi_bit(1'b1);
      cs_high();
      checks++;
      if (wr_cnt - base !== 40) begin
         failures++;
         $display("FAIL abort_writes got=%0d want=40", wr_cnt - base);
      end
      checks++;
      if (wr_addr_log[base+39] !== 6'd39 || wr_data_log[base+39] !== 16'd117) begin
         failures++;
         $display("FAIL abort_last got=%0d/%h want=39/0075", wr_addr_log[base+39], wr_data_log[base+39]);
      end
      checks++;
      if (fd_cnt !== fd0 || bus.write_buffer !== 1'b1) begin
         failures++;
         $display("FAIL abort_no_flip got=%0d/%b want=%0d/1", fd_cnt, bus.write_buffer, fd0);
      end
      base = wr_cnt;
      cs_low();
      spi_word(16'h0BAD);
      cs_high();
      checks++;
      if (wr_cnt - base !== 1 || wr_addr_log[base] !== 6'd0 || wr_data_log[base] !== 16'h0BAD) begin
         failures++;
         $display("FAIL abort_restart got=%0d/%0d/%h want=1/0/0bad",
                  wr_cnt - base, wr_addr_log[base], wr_data_log[base]);
      end
   endtask

   task automatic test_reset_mid_word();
      int base;
      logic [WB+AB+4:0] outs;
      cs_low();
      for (int i = 0; i < 7; i++) spi_bit(1'b1);
      @(negedge pixel_clk);
      n_reset = 1'b0;
      #1;
      outs = {bus.write_data, bus.write_addr, bus.write_en, bus.write_buffer,
              bus.frame_done, bus.overrun, bus.spi_miso};
      checks++;
      if (outs !== '0) begin
         failures++;
         $display("FAIL midreset_outputs got=%h want=0", outs);
      end
      bus.spi_cs_n = 1'b1;
      repeat (4) @(negedge pixel_clk);
      n_reset = 1'b1;
      repeat (4) @(negedge pixel_clk);
      base = wr_cnt;
      cs_low();
      spi_word(16'h7E81);
      cs_high();
      checks++;
      if (wr_cnt - base !== 1 || wr_addr_log[base] !== 6'd0 || wr_data_log[base] !== 16'h7E81) begin
         failures++;
         $display("FAIL midreset_next got=%0d/%0d/%h want=1/0/7e81",
                  wr_cnt - base, wr_addr_log[base], wr_data_log[base]);
      end
   endtask

`ifdef SPI_ECHO_EN
   task automatic test_echo();
      cs_low();
      spi_word(16'h1234);
      checks++;
      if (echo_rx !== 16'h0000) begin
         failures++;
         $display("FAIL echo_first got=%h want=0000", echo_rx);
      end
      spi_word(16'hABCD);
      checks++;
      if (echo_rx !== 16'h1234) begin
         failures++;
         $display("FAIL echo_second got=%h want=1234", echo_rx);
      end
      cs_high();
      checks++;
      if (bus.spi_miso !== 1'b0) begin
         failures++;
         $display("FAIL echo_idle got=%b want=0", bus.spi_miso);
      end
   endtask
`endif

   initial begin
      bus.spi_clk  = 1'b0;
      bus.spi_cs_n = 1'b1;
      bus.spi_mosi = 1'b0;
      echo_rx      = '0;
      test_reset();
      test_single_word();
      test_full_frame();
      test_overrun();
      test_abort();
      test_reset_mid_word();
`ifdef SPI_ECHO_EN
      test_echo();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
